seg7_scan_ctrl: RTL

//   Time-multiplexed scan controller for an N-digit common-anode 7-segment display.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_lut.sv | 37 +++
 rtl/seg7_scan_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns and FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package seg7_pkg;

  // Segment patterns, bit order {dp,g,f,e,d,c,b,a}, active-low, dp off
  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  // Scan FSM: all anodes off (BLANK) or one digit lit (DRIVE)
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_lut.sv
// BCD digit decoder: 4-bit code + dp + blank -> active-low {dp,g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] pat;

  // Pattern lookup; codes 10-15 show a dash, blank clears a-g, dp is independent of blank
  always_comb begin
    pat = SEG_DASH;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    seg = blank ? SEG_OFF : pat;
    if (dp) begin
      seg[7] = 1'b0;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for an N-digit common-anode display with a double-buffered BCD word.
// Latency: a loaded word first shows in digit 0 of the frame after the next FRAME pulse; AN/SEG registered.
// Backpressure: READY drops once a word is pending; LOAD is ignored until the pending word moves to active.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int DIGIT_CYC   = 50000,
  parameter int BLANK_CYC   = 16,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    LOAD,
  input  logic [4*N_DIGITS-1:0]   DATA_IN,
  input  logic [N_DIGITS-1:0]     DP_IN,
  output logic                    READY,
  output logic [N_DIGITS-1:0]     AN,
  output logic [7:0]              SEG,
  output logic                    FRAME
);

  localparam int MAX_CYC = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IW      = $clog2(N_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DIG_LAST   = CW'(DIGIT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*N_DIGITS-1:0]   act_dat;
  logic [N_DIGITS-1:0]     act_dp;
  logic [4*N_DIGITS-1:0]   pend_dat;
  logic [N_DIGITS-1:0]     pend_dp;

  logic                    take_pend;
  logic [4*N_DIGITS-1:0]   view_dat;
  logic [N_DIGITS-1:0]     view_dp;
  logic [3:0]              cur_bcd;
  logic                    cur_dp;
  logic                    upper_nz;
  logic                    lz_blank;
  logic [N_DIGITS-1:0]     an_drive;
  logic [7:0]              lut_seg;

  // The word being decoded: on the FRAME cycle a full pending buffer is about to become active,
  // so look through to it in case DRIVE starts on that same edge (BLANK_CYC=1)
  always_comb begin
    take_pend = FRAME && !READY;
    view_dat  = take_pend ? pend_dat : act_dat;
    view_dp   = take_pend ? pend_dp  : act_dp;
  end

  // Select the current digit, its anode pattern and whether it and all higher digits are zero
  always_comb begin
    cur_bcd  = 4'd0;
    cur_dp   = 1'b0;
    upper_nz = 1'b0;
    an_drive = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_bcd     = view_dat[4*i +: 4];
        cur_dp      = view_dp[i];
        an_drive[i] = 1'b0;
      end
      if ((IW'(i) >= idx) && (view_dat[4*i +: 4] != 4'd0)) begin
        upper_nz = 1'b1;
      end
    end
    lz_blank = (LZ_SUPPRESS != 0) && (idx != '0) && !upper_nz;
  end

  seg7_lut u_lut (
    .bcd   (cur_bcd),
    .dp    (cur_dp),
    .blank (lz_blank),
    .seg   (lut_seg)
  );

  // Scan FSM, buffer handshake and registered pin outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_BLANK;
      cnt      <= '0;
      idx      <= '0;
      act_dat  <= '0;
      act_dp   <= '0;
      pend_dat <= '0;
      pend_dp  <= '0;
      READY    <= 1'b1;
      AN       <= '1;
      SEG      <= SEG_OFF;
      FRAME    <= 1'b0;
    end else begin
      FRAME <= 1'b0;

      // Transfer wins on the FRAME cycle; a LOAD there only lands if pending was empty
      if (take_pend) begin
        act_dat <= pend_dat;
        act_dp  <= pend_dp;
        READY   <= 1'b1;
      end else if (LOAD && READY) begin
        pend_dat <= DATA_IN;
        pend_dp  <= DP_IN;
        READY    <= 1'b0;
      end

      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= ST_DRIVE;
            cnt   <= '0;
            AN    <= an_drive;
            SEG   <= lut_seg;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (cnt == DIG_LAST) begin
            state <= ST_BLANK;
            cnt   <= '0;
            AN    <= '1;
            SEG   <= SEG_OFF;
            if (idx == IDX_LAST) begin
              idx   <= '0;
              FRAME <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
